// File: rtl/am2910_pkg.sv
// -----------------------------------------------------------------------------
// am2910_pkg
// Shared definitions for the Am2910-style microprogram sequencer and the
// external micro-stack it drives:
//   opcode_e   : the sixteen microinstruction opcodes (JZ .. TWB)
//   stack_op_e : stack command encoding on stack_op (HOLD/PUSH/POP/RESET)
//   y_sel_e    : source selected onto the Y address bus
//   r_act_e    : action applied to the register/counter R at the clock edge
// -----------------------------------------------------------------------------
package am2910_pkg;

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_JSRP = 4'd5,
        OP_CJV  = 4'd6,
        OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,
        OP_RPCT = 4'd9,
        OP_CRTN = 4'd10,
        OP_CJPP = 4'd11,
        OP_LDCT = 4'd12,
        OP_LOOP = 4'd13,
        OP_CONT = 4'd14,
        OP_TWB  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        STACK_HOLD  = 2'b00,
        STACK_PUSH  = 2'b01,
        STACK_POP   = 2'b10,
        STACK_RESET = 2'b11
    } stack_op_e;

    typedef enum logic [2:0] {
        Y_ZERO = 3'd0,
        Y_D    = 3'd1,
        Y_UPC  = 3'd2,
        Y_R    = 3'd3,
        Y_F    = 3'd4
    } y_sel_e;

    typedef enum logic [1:0] {
        R_HOLD = 2'd0,
        R_LOAD = 2'd1,
        R_DEC  = 2'd2
    } r_act_e;

endpackage

// File: rtl/am2910_idecode.sv
// -----------------------------------------------------------------------------
// am2910_idecode
// Purely combinational instruction decoder for the sequencer. Given the
// opcode, the resolved condition and the R-is-zero flag it selects the Y
// source, the stack command, the R action and the three source strobes.
// Ports:
//   i       in  [3:0]  opcode
//   pass    in         condition passes (ccen_n | ~cc_n)
//   rz      in         register/counter R equals zero (pre-edge value)
//   y_sel   out        Y source select
//   stack_op out       stack command
//   r_act   out        R action
//   pl_n, map_n, vect_n out  source-enable strobes, exactly one low
// -----------------------------------------------------------------------------
module am2910_idecode
    import am2910_pkg::*;
(
    input  logic [3:0] i,
    input  logic       pass,
    input  logic       rz,
    output y_sel_e     y_sel,
    output stack_op_e  stack_op,
    output r_act_e     r_act,
    output logic       pl_n,
    output logic       map_n,
    output logic       vect_n
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        y_sel    = Y_UPC;
        stack_op = STACK_HOLD;
        r_act    = R_HOLD;
        pl_n     = 1'b0;
        map_n    = 1'b1;
        vect_n   = 1'b1;

        case (opcode_e'(i))
            OP_JZ: begin
                y_sel    = Y_ZERO;
                stack_op = STACK_RESET;
            end
            OP_CJS: begin
                if (pass) begin
                    y_sel    = Y_D;
                    stack_op = STACK_PUSH;
                end
            end
            OP_JMAP: begin
                y_sel = Y_D;
                pl_n  = 1'b1;
                map_n = 1'b0;
            end
            OP_CJP: begin
                if (pass) y_sel = Y_D;
            end
            OP_PUSH: begin
                stack_op = STACK_PUSH;
                if (pass) r_act = R_LOAD;
            end
            OP_JSRP: begin
                stack_op = STACK_PUSH;
                y_sel    = pass ? Y_D : Y_R;
            end
            OP_CJV: begin
                if (pass) y_sel = Y_D;
                pl_n   = 1'b1;
                vect_n = 1'b0;
            end
            OP_JRP: begin
                y_sel = pass ? Y_D : Y_R;
            end
            OP_RFCT: begin
                if (!rz) begin
                    y_sel = Y_F;
                    r_act = R_DEC;
                end else begin
                    stack_op = STACK_POP;
                end
            end
            OP_RPCT: begin
                if (!rz) begin
                    y_sel = Y_D;
                    r_act = R_DEC;
                end
            end
            OP_CRTN: begin
                if (pass) begin
                    y_sel    = Y_F;
                    stack_op = STACK_POP;
                end
            end
            OP_CJPP: begin
                if (pass) begin
                    y_sel    = Y_D;
                    stack_op = STACK_POP;
                end
            end
            OP_LDCT: begin
                r_act = R_LOAD;
            end
            OP_LOOP: begin
                if (pass) stack_op = STACK_POP;
                else      y_sel    = Y_F;
            end
            OP_CONT: begin
                y_sel = Y_UPC;
            end
            OP_TWB: begin
                // Three-way branch: pass exits the loop, otherwise keep
                // looping to F while counting R down, and fall out to D
                // once R is exhausted.
                if (pass) begin
                    stack_op = STACK_POP;
                end else if (!rz) begin
                    y_sel = Y_F;
                    r_act = R_DEC;
                end else begin
                    y_sel    = Y_D;
                    stack_op = STACK_POP;
                end
            end
            default: begin
                y_sel = Y_UPC;
            end
        endcase
    end

endmodule

// File: rtl/am2910_sequencer.sv
// -----------------------------------------------------------------------------
// am2910_sequencer
// Am2910-style microprogram sequencer. Holds the microprogram counter (uPC)
// and the register/counter R, drives the next microaddress Y combinationally
// and commands an external stack.
// Optional feature: define AM2910_RLD_EN to add the rld_n port, which forces
// R <= D on any cycle regardless of opcode.
// Ports:
//   clk          in          rising-edge clock
//   rst          in          synchronous active-high reset
//   i            in  [3:0]   opcode
//   cc_n         in          condition code, low = true
//   ccen_n       in          condition enable, high forces pass
//   ci           in          carry-in to the uPC incrementer
//   rld_n        in          R load override, active low (AM2910_RLD_EN only)
//   d            in  [AW-1:0] direct branch / load data
//   y            out [AW-1:0] next microaddress
//   pl_n, map_n, vect_n out  source-enable strobes
//   stack_op     out [1:0]   stack command
//   stack_din    out [AW-1:0] push data (uPC)
//   stack_dout   in  [AW-1:0] top of stack F
//   stack_full_n in          stack full flag
//   full_n       out         stack full flag, passed through
// -----------------------------------------------------------------------------
module am2910_sequencer
    import am2910_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic          ci,
`ifdef AM2910_RLD_EN
    input  logic          rld_n,
`endif
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          pl_n,
    output logic          map_n,
    output logic          vect_n,
    output logic [1:0]    stack_op,
    output logic [AW-1:0] stack_din,
    input  logic [AW-1:0] stack_dout,
    input  logic          stack_full_n,
    output logic          full_n
);

    logic [AW-1:0] upc;
    logic [AW-1:0] r;

    logic      pass;
    logic      rz;
    y_sel_e    dec_y_sel;
    stack_op_e dec_stack_op;
    r_act_e    dec_r_act;
    logic      dec_pl_n;
    logic      dec_map_n;
    logic      dec_vect_n;

    assign pass = ccen_n | ~cc_n;
    assign rz   = (r == '0);

    am2910_idecode u_idecode (
        .i        (i),
        .pass     (pass),
        .rz       (rz),
        .y_sel    (dec_y_sel),
        .stack_op (dec_stack_op),
        .r_act    (dec_r_act),
        .pl_n     (dec_pl_n),
        .map_n    (dec_map_n),
        .vect_n   (dec_vect_n)
    );

    // Reset overrides the decoded outputs in the same cycle, not just at
    // the clock edge, so the stack sees RESET while rst is high.
    always_comb begin
        y = '0;
        if (!rst) begin
            case (dec_y_sel)
                Y_ZERO:  y = '0;
                Y_D:     y = d;
                Y_UPC:   y = upc;
                Y_R:     y = r;
                Y_F:     y = stack_dout;
                default: y = '0;
            endcase
        end
    end

    assign stack_op  = rst ? STACK_RESET : dec_stack_op;
    assign pl_n      = rst ? 1'b1 : dec_pl_n;
    assign map_n     = rst ? 1'b1 : dec_map_n;
    assign vect_n    = rst ? 1'b1 : dec_vect_n;
    assign stack_din = upc;
    assign full_n    = stack_full_n;

    // NOTE: registers update with non-blocking assignments so every
    // always_ff reads the pre-edge values of upc and r.
    always_ff @(posedge clk) begin
        // NOTE: only these two architectural registers are reset; the
        // decode path is combinational and needs no state clearing.
        if (rst) begin
            upc <= '0;
            r   <= '0;
        end else begin
            // Incrementer wraps modulo 2^AW.
            upc <= y + {{(AW-1){1'b0}}, ci};
`ifdef AM2910_RLD_EN
            if (!rld_n) begin
                r <= d;
            end else
`endif
            begin
                case (dec_r_act)
                    R_LOAD:  r <= d;
                    R_DEC:   r <= r - AW'(1);
                    default: r <= r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_am2910_sequencer.sv
// -----------------------------------------------------------------------------
// tb_am2910_sequencer
// Self-checking bench for am2910_sequencer: directed scenarios followed by
// randomized opcodes, compared every cycle against a behavioural model of
// the sequencer (uPC, R and the opcode table) kept in the bench.
// -----------------------------------------------------------------------------
module tb_am2910_sequencer;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    i;
    logic          cc_n;
    logic          ccen_n;
    logic          ci;
`ifdef AM2910_RLD_EN
    logic          rld_n;
`endif
    logic [AW-1:0] d;
    logic [AW-1:0] y;
    logic          pl_n;
    logic          map_n;
    logic          vect_n;
    logic [1:0]    stack_op;
    logic [AW-1:0] stack_din;
    logic [AW-1:0] stack_dout;
    logic          stack_full_n;
    logic          full_n;

    always #5 clk = ~clk;

    am2910_sequencer #(.AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i            (i),
        .cc_n         (cc_n),
        .ccen_n       (ccen_n),
        .ci           (ci),
`ifdef AM2910_RLD_EN
        .rld_n        (rld_n),
`endif
        .d            (d),
        .y            (y),
        .pl_n         (pl_n),
        .map_n        (map_n),
        .vect_n       (vect_n),
        .stack_op     (stack_op),
        .stack_din    (stack_din),
        .stack_dout   (stack_dout),
        .stack_full_n (stack_full_n),
        .full_n       (full_n)
    );

    int errors = 0;
    int checks = 0;

    // Model state and the expectations computed for the current cycle.
    logic [AW-1:0] m_upc;
    logic [AW-1:0] m_r;
    logic [AW-1:0] e_y;
    logic [1:0]    e_op;
    logic          e_pl_n, e_map_n, e_vect_n;
    logic [AW-1:0] e_next_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the opcode table written out directly in terms of
    // the next address value and stack command.
    task automatic model_eval();
        bit pass;
        bit rz;
        pass     = ccen_n || !cc_n;
        rz       = (m_r == 0);
        e_y      = m_upc;
        e_op     = 2'b00;
        e_pl_n   = 1'b0;
        e_map_n  = 1'b1;
        e_vect_n = 1'b1;
        e_next_r = m_r;
        case (i)
            4'd0:  begin e_y = 0; e_op = 2'b11; end
            4'd1:  if (pass) begin e_y = d; e_op = 2'b01; end
            4'd2:  begin e_y = d; e_pl_n = 1'b1; e_map_n = 1'b0; end
            4'd3:  if (pass) e_y = d;
            4'd4:  begin e_op = 2'b01; if (pass) e_next_r = d; end
            4'd5:  begin e_op = 2'b01; e_y = pass ? d : m_r; end
            4'd6:  begin if (pass) e_y = d; e_pl_n = 1'b1; e_vect_n = 1'b0; end
            4'd7:  e_y = pass ? d : m_r;
            4'd8:  if (!rz) begin e_y = stack_dout; e_next_r = m_r - 1; end
                   else e_op = 2'b10;
            4'd9:  if (!rz) begin e_y = d; e_next_r = m_r - 1; end
            4'd10: if (pass) begin e_y = stack_dout; e_op = 2'b10; end
            4'd11: if (pass) begin e_y = d; e_op = 2'b10; end
            4'd12: e_next_r = d;
            4'd13: if (pass) e_op = 2'b10; else e_y = stack_dout;
            4'd14: e_y = m_upc;
            4'd15: if (pass) e_op = 2'b10;
                   else if (!rz) begin e_y = stack_dout; e_next_r = m_r - 1; end
                   else begin e_y = d; e_op = 2'b10; end
            default: e_y = m_upc;
        endcase
`ifdef AM2910_RLD_EN
        if (!rld_n) e_next_r = d;
`endif
        if (rst) begin
            e_y      = 0;
            e_op     = 2'b11;
            e_pl_n   = 1'b1;
            e_map_n  = 1'b1;
            e_vect_n = 1'b1;
            e_next_r = 0;
        end
    endtask

    // Sample on the falling edge, with inputs stable since just after the
    // previous rising edge.
    task automatic settle();
        @(negedge clk);
        model_eval();
        check("y",         y,         e_y);
        check("stack_op",  stack_op,  e_op);
        check("pl_n",      pl_n,      e_pl_n);
        check("map_n",     map_n,     e_map_n);
        check("vect_n",    vect_n,    e_vect_n);
        check("stack_din", stack_din, m_upc);
        check("full_n",    full_n,    stack_full_n);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_upc = 0;
        else     m_upc = e_y + AW'(ci);
        m_r = e_next_r;
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic en_n, input logic c_n,
                         input logic c, input logic [AW-1:0] dd, input logic [AW-1:0] f);
        i          = op;
        ccen_n     = en_n;
        cc_n       = c_n;
        ci         = c;
        d          = dd;
        stack_dout = f;
    endtask

    int cnt;

    initial begin
        rst          = 1'b1;
        stack_full_n = 1'b1;
`ifdef AM2910_RLD_EN
        rld_n        = 1'b1;
`endif
        drive(4'd14, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000);
        m_upc = 0;
        m_r   = 0;
        @(posedge clk);
        #1;

        // Reset held: Y forced to zero and stack reset, then count up.
        settle();
        check("rst_y", y, 12'h000);
        check("rst_stack_op", stack_op, 2'b11);
        tick();
        rst = 1'b0;
        settle();
        check("cont_y0", y, 12'h000);
        tick();
        settle();
        check("cont_y1", y, 12'h001);
        tick();

        // Reach uPC=0x010, then conditional call and return.
        drive(4'd3, 1'b1, 1'b1, 1'b1, 12'h00F, 12'h000);
        settle(); tick();
        drive(4'd1, 1'b0, 1'b0, 1'b0, 12'h200, 12'h000);
        stack_full_n = 1'b0;  // push still issued when the stack is full
        settle();
        check("cjs_y", y, 12'h200);
        check("cjs_op", stack_op, 2'b01);
        check("cjs_din", stack_din, 12'h010);
        tick();
        stack_full_n = 1'b1;
        drive(4'd10, 1'b0, 1'b0, 1'b0, 12'h000, 12'h010);
        settle();
        check("crtn_y", y, 12'h010);
        check("crtn_op", stack_op, 2'b10);
        tick();

        // Load counter with 3, repeat-PC until exhausted.
        drive(4'd12, 1'b1, 1'b1, 1'b0, 12'h003, 12'h000);
        settle(); tick();
        for (int k = 0; k < 4; k++) begin
            drive(4'd9, 1'b1, 1'b1, 1'b1, 12'h050, 12'h000);
            settle();
            check("rpct_y", y, (k < 3) ? 12'h050 : 12'h051);
            tick();
        end

        // Three-way branch with R=2, condition failing.
        drive(4'd12, 1'b1, 1'b1, 1'b0, 12'h002, 12'h000);
        settle(); tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'd15, 1'b0, 1'b1, 1'b0, 12'h123, 12'h3A5);
            settle();
            check("twb_fail_y", y, (k < 2) ? 12'h3A5 : 12'h123);
            check("twb_fail_op", stack_op, (k < 2) ? 2'b00 : 2'b10);
            tick();
        end
        drive(4'd15, 1'b1, 1'b1, 1'b0, 12'h456, 12'h3A5);
        settle();
        check("twb_pass_y", y, 12'h123);
        check("twb_pass_op", stack_op, 2'b10);
        tick();

        // Map and vector strobes, then incrementer wrap.
        drive(4'd2, 1'b0, 1'b1, 1'b0, 12'h0AA, 12'h000);
        settle();
        check("jmap_map_n", map_n, 1'b0);
        check("jmap_pl_n", pl_n, 1'b1);
        tick();
        drive(4'd6, 1'b1, 1'b1, 1'b0, 12'h0BB, 12'h000);
        settle();
        check("cjv_vect_n", vect_n, 1'b0);
        check("cjv_pl_n", pl_n, 1'b1);
        tick();
        drive(4'd3, 1'b1, 1'b1, 1'b1, 12'hFFF, 12'h000);
        settle();
        check("wrap_y", y, 12'hFFF);
        tick();
        drive(4'd14, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000);
        settle();
        check("wrap_upc", y, 12'h000);
        tick();

`ifdef AM2910_RLD_EN
        // rld_n overrides the RFCT decrement: R becomes 7, not 4.
        drive(4'd12, 1'b1, 1'b1, 1'b0, 12'h005, 12'h000);
        settle(); tick();
        drive(4'd8, 1'b1, 1'b1, 1'b0, 12'h007, 12'h222);
        rld_n = 1'b0;
        settle(); tick();
        rld_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            drive(4'd9, 1'b1, 1'b1, 1'b0, 12'h0C0, 12'h000);
            settle();
            if (y == 12'h0C0) cnt++;
            tick();
        end
        check("rld_count", cnt, 7);
`endif

        // Randomized opcodes against the model.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                  AW'($urandom), AW'($urandom));
            stack_full_n = 1'($urandom);
`ifdef AM2910_RLD_EN
            rld_n = ($urandom_range(0, 7) != 0);
`endif
            // Bias toward small counts so R reaches zero often.
            if (i == 4'd12 && $urandom_range(0, 1) == 1) d = AW'($urandom_range(0, 3));
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/am2910_sequencer.md
AM2910_SEQUENCER -- requirements
Module: am2910_sequencer

Interface
REQ-001 SHALL have parameter AW, default 12: width of address, D, register/counter and stack data.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port i  input  4  microinstruction opcode 0..15.
REQ-005 SHALL have port cc_n  input  1  condition code, active low (low = true).
REQ-006 SHALL have port ccen_n  input  1  condition enable, active low; when high the condition is forced to pass.
REQ-007 SHALL have port ci  input  1  carry-in to the uPC incrementer.
REQ-008 SHALL have port rld_n  input  1  register/counter load override, active low (present only with AM2910_RLD_EN).
REQ-009 SHALL have port d  input  AW  direct branch/load data.
REQ-010 SHALL have port y  output  AW  next microaddress, combinational.
REQ-011 SHALL have port pl_n, map_n, vect_n  output  1 each  source-enable strobes, active low.
REQ-012 SHALL have port stack_op  output  2  stack command: 00 HOLD, 01 PUSH, 10 POP, 11 RESET.
REQ-013 SHALL have port stack_din  output  AW  push data, always equal to the uPC register.
REQ-014 SHALL have port stack_dout  input  AW  top-of-stack value F.
REQ-015 SHALL have port stack_full_n  input  1  stack full flag, passed through unchanged to full_n.
REQ-016 SHALL have port full_n  output  1  stack full, active low.

Function
REQ-017 SHALL define pass = ccen_n | ~cc_n; fail = ~pass; rz = (R == 0).
REQ-018 SHALL, per opcode, drive y, stack_op, and the R action combinationally as follows; unlisted stack_op is HOLD and unlisted R is hold.
- 0 JZ: y=0; RESET.
- 1 CJS: pass: y=D, PUSH. Fail: y=uPC.
- 2 JMAP: y=D; map_n=0.
- 3 CJP: pass: y=D. Fail: y=uPC.
- 4 PUSH: y=uPC; PUSH; pass: R<=D.
- 5 JSRP: PUSH. Pass: y=D. Fail: y=R.
- 6 CJV: pass: y=D. Fail: y=uPC. vect_n=0.
- 7 JRP: pass: y=D. Fail: y=R.
- 8 RFCT: if !rz: y=F, R<=R-1. If rz: y=uPC, POP.
- 9 RPCT: if !rz: y=D, R<=R-1. If rz: y=uPC.
- 10 CRTN: pass: y=F, POP. Fail: y=uPC.
- 11 CJPP: pass: y=D, POP. Fail: y=uPC.
- 12 LDCT: y=uPC; R<=D.
- 13 LOOP: pass: y=uPC, POP. Fail: y=F.
- 14 CONT: y=uPC.
- 15 TWB: if pass: y=uPC, POP. If fail and !rz: y=F, R<=R-1. If fail and rz: y=D, POP.
REQ-019 SHALL drive pl_n=0 for every opcode except 2 and 6, where pl_n=1; exactly one strobe is low per cycle.
REQ-020 SHALL update uPC <= y + ci (mod 2^AW) on every non-reset clock; 12'hFFF+1 wraps to 0.
REQ-021 SHALL evaluate R tests on the pre-edge R value; R decrement never occurs when rz.
REQ-022 SHALL issue PUSH even when stack_full_n=0; overflow handling belongs to the stack, and y is unaffected.
REQ-023 SHALL give rld_n=0 priority over any opcode R action: R<=D.

Reset
REQ-024 SHALL, while rst=1, drive y=0, stack_op=11, pl_n=map_n=vect_n=1, and at the clock edge set uPC<=0 and R<=0.
REQ-025 SHALL let rst override any in-flight opcode; the first cycle after rst deasserts decodes i normally from uPC=0.

Configuration
REQ-026 SHALL, with AM2910_RLD_EN defined, include port rld_n per REQ-023.
REQ-027 SHALL, without AM2910_RLD_EN, omit port rld_n; R then loads only via opcodes 4 and 12.

Structure
REQ-028 SHALL place opcode constants (JZ..TWB) and stack_op encodings in shared package am2910_pkg, used by the stack as well.
REQ-029 SHALL implement decode as one combinational sub-module am2910_idecode (i, pass, rz -> y source select, stack_op, R action, strobes); uPC and R registers remain in the top module.

Verification
REQ-030 SHALL cover: rst=1 one cycle -> y=0, stack_op=11; then i=14 -> y=0, next y=1 with ci=1.
REQ-031 SHALL cover: uPC=0x010, i=1, ccen_n=0, cc_n=0, d=0x200 -> y=0x200, stack_op=01, stack_din=0x010; then i=10 pass with stack_dout=0x010 -> y=0x010, stack_op=10.
REQ-032 SHALL cover: i=12, d=3, then i=9 for four cycles with d=0x050 -> y=0x050 three times (R=3,2,1), then y=uPC with R=0.
REQ-033 SHALL cover: i=15 with R=2 and fail -> y=F twice, then y=d with stack_op=10; repeated with pass -> y=uPC, stack_op=10.
REQ-034 SHALL cover: i=2 -> map_n=0, pl_n=1; i=6 -> vect_n=0, pl_n=1; y=0xFFF with ci=1 -> next uPC=0.
REQ-035 SHALL cover, with AM2910_RLD_EN: rld_n=0 during i=8 with R=5, d=7 -> R=7 and not 4.
